hazard_scoreboard_unit: RTL and testbench

//  Parametrised hazard controller for the 5-stage pipeline, replacing single-cycle load-use detection.

---
 rtl/hazard_scoreboard_unit.sv | 106 ++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// Purpose : per-register countdown scoreboard driving PC/IF-ID stall, ID/EX bubble and branch flushes.
// Latency : hazard outputs are combinational from ID fields and scoreboard state; scoreboard updates each clk.
// Backpressure: a hazard holds PC and IF/ID and bubbles ID/EX until every source is forwardable.
//
// Ports:
//   clk, rst_n                    pipeline clock, asynchronous active-low reset
//   id_valid/rs1/rs2/rs*_used     ID instruction source operands
//   id_rd/id_reg_write/id_class   ID destination and producer class (00/11 ALU, 01 load, 10 mul/div)
//   ex_branch_taken               EX resolved a taken branch; the ID instruction is squashed
//   pc_stall/ifid_stall           hold PC and IF/ID
//   idex_bubble                   insert a NOP into ID/EX
//   ifid_flush/idex_flush         squash IF/ID and ID/EX
//   stall_cycles                  saturating count of hazard-stalled cycles
module hazard_scoreboard_unit #(
   parameter int REG_CNT  = 32,
   parameter int REG_W    = 5,
   parameter int LOAD_LAT = 1,
   parameter int MUL_LAT  = 4,
   parameter int CNT_W    = 3,
   parameter int STAT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_rs1,
   input  logic [REG_W-1:0]  id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_W-1:0]  id_rd,
   input  logic              id_reg_write,
   input  logic [1:0]        id_class,
   input  logic              ex_branch_taken,
   output logic              pc_stall,
   output logic              ifid_stall,
   output logic              idex_bubble,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic [STAT_W-1:0] stall_cycles
);

   // cnt[r]: cycles remaining before r's producer result can be forwarded; 0 = free.
   logic [CNT_W-1:0] cnt [REG_CNT];
   logic [CNT_W-1:0] lat;
   logic             raw;
   logic             waw;
   logic             hazard;
   logic             issue;

   always_comb begin
      lat = '0;
      case (id_class)
         2'b01:   lat = CNT_W'(LOAD_LAT);
         2'b10:   lat = CNT_W'(MUL_LAT);
         default: lat = '0;
      endcase
   end

   always_comb begin
      raw = (id_rs1_used && (id_rs1 != '0) && (cnt[id_rs1] != '0)) ||
            (id_rs2_used && (id_rs2 != '0) && (cnt[id_rs2] != '0));
      // A younger producer must not finish before an older one still in flight to the same rd.
      waw = id_reg_write && (id_rd != '0) && (cnt[id_rd] > lat);
      hazard = id_valid && (raw || waw);
      issue  = id_valid && !hazard && !ex_branch_taken;
   end

   // Branch squash outranks the stall: the stalled instruction is being discarded anyway.
   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      if (ex_branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (hazard) begin
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < REG_CNT; r++) begin
            cnt[r] <= '0;
         end
         stall_cycles <= '0;
      end else begin
         cnt[0] <= '0;
         for (int r = 1; r < REG_CNT; r++) begin
            // Issue load overrides the decrement; an ALU issue loads 0, freeing rd.
            if (issue && id_reg_write && (id_rd == REG_W'(r))) begin
               cnt[r] <= lat;
            end else if (cnt[r] != '0) begin
               cnt[r] <= cnt[r] - CNT_W'(1);
            end
         end
         if (hazard && !ex_branch_taken && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + STAT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
`timescale 1ns/1ps
module tb_hazard_scoreboard_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid = 1'b0;
   logic [4:0]  id_rs1 = '0;
   logic [4:0]  id_rs2 = '0;
   logic        id_rs1_used = 1'b0;
   logic        id_rs2_used = 1'b0;
   logic [4:0]  id_rd = '0;
   logic        id_reg_write = 1'b0;
   logic [1:0]  id_class = '0;
   logic        ex_branch_taken = 1'b0;
   logic        pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush;
   logic [15:0] stall_cycles;

   int tests = 0;
   int fails = 0;

   hazard_scoreboard_unit dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_class(id_class),
      .ex_branch_taken(ex_branch_taken),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   // {pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush}
   function automatic logic [4:0] outs();
      return {pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                            input logic u2, input logic [4:0] rd, input logic wr, input logic [1:0] cls);
      id_valid = 1'b1;
      id_rs1 = rs1; id_rs1_used = u1;
      id_rs2 = rs2; id_rs2_used = u2;
      id_rd = rd; id_reg_write = wr; id_class = cls;
   endtask

   task automatic idle();
      id_valid = 1'b0; id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_reg_write = 1'b0;
      ex_branch_taken = 1'b0;
   endtask

   // Counts stalled cycles of the instruction in ID; returns at the negedge of its issue cycle.
   task automatic count_stalls(output int n);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (!pc_stall) return;
         n++;
         tick();
      end
   endtask

   task automatic test_reset();
      #2;
      tests++;
      if (outs() !== 5'b00000) begin fails++; $display("FAIL reset_outs got=%b want=00000", outs()); end
      tests++;
      if (stall_cycles !== 16'd0) begin fails++; $display("FAIL reset_stat got=%0d want=0", stall_cycles); end
      @(negedge clk); rst_n = 1'b1;
      tick();
   endtask

   task automatic test_load_use();
      set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'b01);
      @(negedge clk);
      tests++;
      if (outs() !== 5'b00000) begin fails++; $display("FAIL load_issue got=%b want=00000", outs()); end
      tick();
      set_instr(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 2'b00);
      @(negedge clk);
      tests++;
      if (outs() !== 5'b11100) begin fails++; $display("FAIL load_use_stall got=%b want=11100", outs()); end
      tick();
      @(negedge clk);
      tests++;
      if (outs() !== 5'b00000) begin fails++; $display("FAIL load_use_issue got=%b want=00000", outs()); end
      tests++;
      if (stall_cycles !== 16'd1) begin fails++; $display("FAIL load_use_stat got=%0d want=1", stall_cycles); end
      tick();
      idle();
   endtask

   task automatic test_mul_use();
      int n;
      set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'b10);
      tick();
      set_instr(5'd7, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 2'b00);
      count_stalls(n);
      tests++;
      if (n != 4) begin fails++; $display("FAIL mul_use_stalls got=%0d want=4", n); end
      tests++;
      if (stall_cycles !== 16'd5) begin fails++; $display("FAIL mul_use_stat got=%0d want=5", stall_cycles); end
      tick();
      idle();
   endtask

   task automatic test_x0_alu();
      set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'b01);
      tick();
      set_instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 2'b00);
      @(negedge clk);
      tests++;
      if (outs() !== 5'b00000) begin fails++; $display("FAIL x0_reader got=%b want=00000", outs()); end
      tick();
      set_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 2'b00);
      tick();
      set_instr(5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 2'b11);
      @(negedge clk);
      tests++;
      if (outs() !== 5'b00000) begin fails++; $display("FAIL alu_reader got=%b want=00000", outs()); end
      tick();
      set_instr(5'd4, 1'b0, 5'd4, 1'b1, 5'd11, 1'b1, 2'b00);
      @(negedge clk);
      tests++;
      if (outs() !== 5'b00000) begin fails++; $display("FAIL class11_reader got=%b want=00000", outs()); end
      tests++;
      if (stall_cycles !== 16'd5) begin fails++; $display("FAIL x0_alu_stat got=%0d want=5", stall_cycles); end
      tick();
      idle();
   endtask

   task automatic test_branch();
      int n;
      set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'b10);
      tick();
      // cnt[5]=4: hazard present but the branch squashes it.
      set_instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 2'b00);
      ex_branch_taken = 1'b1;
      @(negedge clk);
      tests++;
      if (outs() !== 5'b00011) begin fails++; $display("FAIL branch_over_stall got=%b want=00011", outs()); end
      tick();
      // Squashed load must not mark x10 busy.
      set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 2'b01);
      @(negedge clk);
      tests++;
      if (stall_cycles !== 16'd5) begin fails++; $display("FAIL branch_stat got=%0d want=5", stall_cycles); end
      tests++;
      if (outs() !== 5'b00011) begin fails++; $display("FAIL branch_flush got=%b want=00011", outs()); end
      tick();
      ex_branch_taken = 1'b0;
      set_instr(5'd10, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 2'b00);
      @(negedge clk);
      tests++;
      if (outs() !== 5'b00000) begin fails++; $display("FAIL squashed_no_set got=%b want=00000", outs()); end
      tick();
      // cnt[5]: 4 -> 3 -> 2 -> 1 across the two branch cycles and the x10 reader.
      set_instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 2'b00);
      count_stalls(n);
      tests++;
      if (n != 1) begin fails++; $display("FAIL branch_decrement got=%0d want=1", n); end
      tick();
      idle();
   endtask

   task automatic test_waw();
      int n;
      set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'b10);
      tick();
      set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'b01);
      count_stalls(n);
      tests++;
      if (n != 3) begin fails++; $display("FAIL waw_stalls got=%0d want=3", n); end
      tick();
      set_instr(5'd9, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 2'b00);
      count_stalls(n);
      tests++;
      if (n != 1) begin fails++; $display("FAIL waw_load_cnt got=%0d want=1", n); end
      tests++;
      if (stall_cycles !== 16'd10) begin fails++; $display("FAIL waw_stat got=%0d want=10", stall_cycles); end
      tick();
      idle();
   endtask

   task automatic test_saturation_reset();
      int n = 0;
      bit done = 1'b0;
      // mul x12 <- x12 stalls 4 of every 5 cycles on itself.
      set_instr(5'd12, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 2'b10);
      for (int i = 0; i < 90000 && !done; i++) begin
         @(negedge clk);
         if (pc_stall) n++;
         if (n >= 65539) done = 1'b1;
         else tick();
      end
      tests++;
      if (!done) begin fails++; $display("FAIL sat_budget got=%0d want=65539", n); end
      tests++;
      if (stall_cycles !== 16'hFFFF) begin fails++; $display("FAIL sat_value got=%h want=ffff", stall_cycles); end
      tests++;
      if (outs() !== 5'b11100) begin fails++; $display("FAIL sat_midstall got=%b want=11100", outs()); end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (outs() !== 5'b00000) begin fails++; $display("FAIL async_rst_outs got=%b want=00000", outs()); end
      tests++;
      if (stall_cycles !== 16'd0) begin fails++; $display("FAIL async_rst_stat got=%0d want=0", stall_cycles); end
      // Every entry cleared: no read or write-after-write hazard on any register.
      for (int r = 1; r < 32; r++) begin
         set_instr(5'(r), 1'b1, 5'(r), 1'b1, 5'(r), 1'b1, 2'b00);
         #1;
         tests++;
         if (pc_stall !== 1'b0) begin fails++; $display("FAIL rst_cnt_clear r=%0d got=%b want=0", r, pc_stall); end
      end
      idle();
      @(negedge clk); rst_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_mul_use();
      test_x0_alu();
      test_branch();
      test_waw();
      test_saturation_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
